// File: rtl/alu_share_pkg.sv
// Shared-ALU controller types: operation codes, controller states and default datapath width.
// Pure declarations; no timing or flow control of its own.
package alu_share_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_SLT  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_grant2.sv
// Two-requester one-hot grant, combinational (zero latency); never grants an idle requester.
// ALU_SHARE_RR_EN selects round-robin on the last-granted port, otherwise port 0 has fixed priority.
module alu_share_grant2 (
    input  logic [1:0] valid_i,
`ifdef ALU_SHARE_RR_EN
    input  logic       last_i,
`endif
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
`ifdef ALU_SHARE_RR_EN
        // On contention the port that did not win last time goes next.
        if (valid_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
`else
        if (valid_i[0]) begin
            grant_o = 2'b01;
        end else if (valid_i[1]) begin
            grant_o = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: accept T, execute T+1, response from T+2.
// One op in flight; requests wait (ready low) while busy and the response holds until its ready (ALU_SHARE_RR_EN: round-robin).
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  alu_op_e          req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  alu_op_e          req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output alu_op_e          alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    output logic             busy,
    output logic             owner
);

    state_e           state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             owner_q;
    logic [1:0]       grant;
    logic             accept;
    logic             rsp_hs;

`ifdef ALU_SHARE_RR_EN
    logic last_q;

    alu_share_grant2 u_grant (
        .valid_i ({req1_valid, req0_valid}),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Reset value 1 makes port 0 win the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= req1_ready;
        end
    end
`else
    alu_share_grant2 u_grant (
        .valid_i ({req1_valid, req0_valid}),
        .grant_o (grant)
    );
`endif

    assign req0_ready = (state_q == ST_IDLE) && grant[0] && req0_valid;
    assign req1_ready = (state_q == ST_IDLE) && grant[1] && req1_valid;
    assign accept     = req0_ready || req1_ready;
    assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= req1_ready ? req1_op : req0_op;
                        a_q     <= req1_ready ? req1_a  : req0_a;
                        b_q     <= req1_ready ? req1_b  : req0_b;
                        owner_q <= req1_ready;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The reserved op code yields zero whatever the ALU returns.
                    res_q   <= (op_q == OP_RSVD) ? '0 : alu_res;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_data   = res_q;
    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
    assign busy       = (state_q != ST_IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU and a response scoreboard.
// Honours ALU_SHARE_RR_EN for the expected grant order.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    alu_op_e      req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_data, alu_a, alu_b, alu_res;
    logic         busy, owner;

    typedef struct packed {
        logic         port;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .busy       (busy),
        .owner      (owner)
    );

    // Stand-in for the external ALU; the reserved code returns junk the controller must mask.
    function automatic logic [W-1:0] alu_fn(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_fn(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        return (op == OP_RSVD) ? '0 : alu_fn(op, a, b);
    endfunction

    always_comb alu_res = alu_fn(alu_op, alu_a, alu_b);

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (failure #%0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (failure #%0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1(tag, (n < 50), 1'b1);
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) sb.push_back('{port: 1'b0, data: exp_fn(req0_op, req0_a, req0_b)});
            if (req1_valid && req1_ready) sb.push_back('{port: 1'b1, data: exp_fn(req1_op, req1_a, req1_b)});
            chk1("rsp_exclusive", rsp0_valid && rsp1_valid, 1'b0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                chk1("sb_rsp_expected", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk1("sb_port", rsp1_valid, mon_e.port);
                    chk1("sb_owner", owner, mon_e.port);
                    chkw("sb_data", rsp_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g[3];
        int gc[3];
        int ng;
        int cyc;
        logic quiet;
        logic seen;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = OP_AND; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = OP_AND; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #12;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
        chkw("rst_rsp_data", rsp_data, 32'h0);
        chkw("rst_alu_op", 32'(alu_op), 32'h0);
        chkw("rst_alu_a", alu_a, 32'h0);
        chkw("rst_alu_b", alu_b, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Contention: both ports request continuously.
        tick();
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'd5; req1_b = 32'd7;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        ng = 0; cyc = 0;
        g = '{0, 0, 0}; gc = '{0, 0, 0};
        while (ng < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (req0_ready || req1_ready) begin
                chk1("arb_one_ready", req0_ready && req1_ready, 1'b0);
                g[ng]  = req1_ready ? 1 : 0;
                gc[ng] = cyc;
                ng++;
            end
        end
        chkw("arb_grants_seen", ng, 3);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_SHARE_RR_EN
        chkw("arb_grant0", g[0], 0);
        chkw("arb_grant1", g[1], 1);
        chkw("arb_grant2", g[2], 0);
`else
        chkw("arb_grant0", g[0], 0);
        chkw("arb_grant1", g[1], 0);
        chkw("arb_grant2", g[2], 0);
`endif
        chkw("arb_b2b_spacing", gc[1] - gc[0], 3);
        chkw("sub_model", exp_fn(OP_SUB, 32'd5, 32'd7), 32'hFFFF_FFFE);
        drain("arb_drain");

        // Single XOR on port 0, check the T / T+1 / T+2 timeline.
        tick();
        req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F;
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        @(negedge clk);
        chk1("xor_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk1("xor_exec_busy", busy, 1'b1);
        chk1("xor_exec_no_rsp", rsp0_valid, 1'b0);
        chkw("xor_alu_a", alu_a, 32'hFFFF_0000);
        chkw("xor_alu_op", 32'(alu_op), 32'(3'b010));
        @(negedge clk);
        chk1("xor_rsp_valid", rsp0_valid, 1'b1);
        chkw("xor_rsp_data", rsp_data, 32'hF0F0_0F0F);
        chk1("xor_rsp1_quiet", rsp1_valid, 1'b0);
        @(negedge clk);
        chk1("xor_idle", busy, 1'b0);

        // Response backpressure on port 1 while port 0 waits.
        tick();
        req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'h0000_00F0; req1_b = 32'h0000_0F00;
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        @(negedge clk);
        chk1("bp_accept", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 32'h0000_FFFF; req0_b = 32'h0000_0FF0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
            chkw("bp_rsp_data", rsp_data, 32'h0000_0FF0);
            chk1("bp_busy", busy, 1'b1);
            chk1("bp_req0_blocked", req0_ready, 1'b0);
            chk1("bp_rsp0_quiet", rsp0_valid, 1'b0);
        end
        tick();
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk1("bp_hs_valid", rsp1_valid, 1'b1);
        tick();
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk1("bp_idle_after", busy, 1'b0);
        chk1("bp_req0_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        drain("bp_drain");

        // Reserved op code must return zero.
        tick();
        req0_valid = 1'b1; req0_op = OP_RSVD; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
        @(negedge clk);
        chk1("rsvd_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chkw("rsvd_alu_op", 32'(alu_op), 32'(3'b111));
        @(negedge clk);
        chk1("rsvd_rsp_valid", rsp0_valid, 1'b1);
        chkw("rsvd_rsp_data", rsp_data, 32'h0);
        drain("rsvd_drain");

        // Asynchronous reset while a port-0 NOR is executing.
        tick();
        req0_valid = 1'b1; req0_op = OP_NOR; req0_a = 32'h0F0F_0F0F; req0_b = 32'h00FF_00FF;
        @(negedge clk);
        chk1("rst_mid_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk1("rst_mid_pre_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_rsp0", rsp0_valid, 1'b0);
        chkw("rst_mid_alu_a", alu_a, 32'h0);
        chkw("rst_mid_alu_b", alu_b, 32'h0);
        chkw("rst_mid_alu_op", 32'(alu_op), 32'h0);
        chk1("rst_mid_owner", owner, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) quiet = 1'b0;
        end
        chk1("rst_no_response", quiet, 1'b1);

        // After reset port 0 wins contention, then port 1 is served.
        tick();
        req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'd10;  req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = OP_AND; req1_a = 32'hFF;  req1_b = 32'h0F;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        chk1("post_rst_p0_wins", req0_ready, 1'b1);
        chk1("post_rst_p1_waits", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req1_ready) seen = 1'b1;
        end
        chk1("post_rst_p1_served", seen, 1'b1);
        tick();
        req1_valid = 1'b0;
        drain("final_drain");
        chkw("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares the single 32-bit combinational ALU datapath (AND/OR/XOR/NOR/ADD/SUB/SLT bit-slice units) between two requesters: port 0 (EX stage) and port 1 (branch/compare unit). It accepts one operation at a time through a valid/ready handshake, drives the shared ALU from registered operands, captures the result, and returns it to the owning requester through a response handshake. It sits between the pipeline front-ends and the ALU instance in the CPU datapath.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  3  operation code (package enum)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available for that port
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_data  out  WIDTH  result (shared by both ports; qualified by rspN_valid)
- alu_op  out  3  op to shared ALU
- alu_a, alu_b  out  WIDTH  operands to shared ALU
- alu_res  in  WIDTH  combinational ALU result
- busy  out  1  high in any state other than IDLE
- owner  out  1  port that owns the current operation

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: grant computed combinationally from req0_valid/req1_valid and arbitration pointer; reqN_ready = (state==IDLE) && grant==N && reqN_valid. On accept: latch op, a, b into op_q/a_q/b_q, owner <= N, -> EXEC. No valid -> stay IDLE.
- EXEC: alu_op/alu_a/alu_b driven from op_q/a_q/b_q (always, in every state); capture res_q <= alu_res; -> RESP.
- RESP: rsp_data = res_q; rsp{owner}_valid = 1, other rsp valid 0. Hold until rsp{owner}_ready; on handshake -> IDLE. Ready on the non-owner response port ignored.
- Op codes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 reserved. Controller passes op unmodified; for 111 it forces res_q = 0.
- Arithmetic wrap/overflow is the ALU's concern; result captured as WIDTH bits, no flags.
- Request operands need only be stable during the accept cycle.
- No new request accepted while busy; requests stay pending (valid held by requester).

## Timing
- Accept in cycle T (IDLE) -> EXEC in T+1 -> rspN_valid from T+2. Minimum 3 cycles per operation; back-to-back accept possible in the cycle after the response handshake.
- rspN_valid, rsp_data, busy, owner all registered/state-derived; reqN_ready combinational from state and valids only (no path from rsp ready).
- Reset (asynchronous, any state, including mid-EXEC/RESP): state IDLE, op_q/a_q/b_q/res_q = 0, so alu_op=0, alu_a=alu_b=0, rsp_data=0; rsp*_valid=0, busy=0, owner=0, pointer such that port 0 wins first. In-flight operation discarded, no response.
- Simultaneous valid in IDLE: resolved by arbitration (see Configuration); only one ready asserted.

## Configuration
- ALU_SHARE_RR_EN defined: round-robin; pointer records last-granted port, updated on accept; on simultaneous requests the other port wins. Single requester always granted.
- Not defined: fixed priority, port 0 always wins; pointer logic absent. Port 1 can starve while port 0 keeps requesting.

## Structure
- Package alu_share_pkg: op-code enum (3-bit, values above), state enum (IDLE/EXEC/RESP), default WIDTH constant.
- One sub-module: alu_share_grant2 — two-input grant logic (fixed or round-robin per macro), inputs valids + pointer, output one-hot grant.
- ALU itself stays outside; this block only connects via alu_op/alu_a/alu_b/alu_res.

## Test plan
- Port 0 XOR a=0xFFFF0000 b=0x0F0F0F0F, rsp0_ready=1 -> accept cycle T, rsp0_valid at T+2, rsp_data=0xF0F00F0F, rsp1_valid stays 0.
- Both ports valid continuously, ADD 1+2 on p0, SUB 5-7 on p1, RR_EN defined -> grants alternate p0,p1,p0; p1 result 0xFFFFFFFE; without macro p0 granted every time.
- Response backpressure: p1 OR 0x00F0|0x0F00, rsp1_ready low 5 cycles -> rsp1_valid and rsp_data=0x00000FF0 held, busy=1, req0_ready=0 throughout; IDLE one cycle after ready.
- Reserved op 111 with a=b=0xFFFFFFFF -> rsp_data=0x00000000 at T+2.
- rst_n asserted during EXEC of p0 NOR -> immediately busy=0, rsp0_valid=0, alu_a/alu_b/alu_op=0; no response after release; next request serviced normally with port 0 priority.
